// File: rtl/sig_capture_pkg.sv
// Shared types for the triggered sample recorder: FSM state type and the
// encoding presented on the state port.
package sig_capture_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } cap_state_t;

endpackage

// File: rtl/sig_capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read.
// Contents are never reset; only the read register is.
module capture_ram #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [D_WIDTH-1:0] wr_data_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [D_WIDTH-1:0] rd_data_o
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  logic [D_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Same-address read/write returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sig_capture.sv
// Triggered sample recorder: arm, wait for a rising crossing of trig_level,
// store a CAP_LEN window. Define PRETRIG_EN to keep PRE_LEN pre-trigger samples.
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int CAP_LEN = 256,
  parameter int PRE_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic [1:0]         state,
  output logic               done,
  output logic [A_WIDTH-1:0] trig_addr
);

`ifdef PRETRIG_EN
  localparam bit PRETRIG = 1'b1;
`else
  localparam bit PRETRIG = 1'b0;
`endif
  // Writes made from the trigger sample onward, trigger included.
  localparam int POST_LEN = PRETRIG ? CAP_LEN - PRE_LEN : CAP_LEN;
  localparam int CW       = $clog2(CAP_LEN + 1);

  cap_state_t         state_q, state_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [D_WIDTH-1:0] prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic               we;
  logic               trig_hit;

`ifdef PRETRIG_EN
  localparam int PW = $clog2(PRE_LEN + 2);
  logic [PW-1:0] pre_count_q, pre_count_d;
`endif

  always_comb begin
    trig_hit = prev_valid_q && (prev_q < trig_level) && (din >= trig_level);
`ifdef PRETRIG_EN
    trig_hit = trig_hit && (pre_count_q >= PW'(PRE_LEN));
`endif
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    trig_addr_d  = trig_addr_q;
    count_d      = count_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    we           = 1'b0;
`ifdef PRETRIG_EN
    pre_count_d  = pre_count_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d      = ARMED;
          wr_ptr_d     = '0;
          prev_valid_d = 1'b0;
`ifdef PRETRIG_EN
          pre_count_d  = '0;
`endif
        end
      end
      ARMED: begin
        if (en) begin
          prev_d       = din;
          prev_valid_d = 1'b1;
`ifdef PRETRIG_EN
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (pre_count_q < PW'(PRE_LEN)) pre_count_d = pre_count_q + 1'b1;
`endif
          if (trig_hit) begin
            we          = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            trig_addr_d = wr_ptr_q;
            count_d     = CW'(1);
            state_d     = (POST_LEN == 1) ? DONE : CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == CW'(POST_LEN - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      trig_addr_q  <= '0;
      count_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`ifdef PRETRIG_EN
      pre_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      trig_addr_q  <= trig_addr_d;
      count_q      <= count_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`ifdef PRETRIG_EN
      pre_count_q  <= pre_count_d;
`endif
    end
  end

  capture_ram #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign state     = state_q;
  assign done      = (state_q == DONE);
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_sig_capture.sv
// Scoreboard bench for sig_capture (CAP_LEN=16, trig_level=128). Expected RAM
// writes are queued as stimulus is driven and popped on readback.
module tb_sig_capture;

  localparam int DW = 8, AW = 8, CAP = 16, PRE = 4;
`ifdef PRETRIG_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif
  localparam int POST = PT ? CAP - PRE : CAP;

  logic          clk = 1'b0;
  logic          rst, en, arm, done;
  logic [DW-1:0] din, lvl, rd_data;
  logic [AW-1:0] rd_addr, trig_addr;
  logic [1:0]    state;

  always #5 clk = ~clk;

  sig_capture #(.D_WIDTH(DW), .A_WIDTH(AW), .CAP_LEN(CAP), .PRE_LEN(PRE)) dut (
    .clk(clk), .rst(rst), .en(en), .arm(arm), .din(din), .trig_level(lvl),
    .rd_addr(rd_addr), .rd_data(rd_data), .state(state), .done(done),
    .trig_addr(trig_addr)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t sbq[$];

  int n_chk = 0, n_fail = 0;
  int m_state, m_wr, m_cnt, m_prev, m_pv, m_trig, m_pre;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = a[7:0];
    e.d = d[7:0];
    sbq.push_back(e);
  endtask

  // Drive one cycle, advance the reference model, compare visible state.
  task automatic step(input logic e, input logic a, input logic [7:0] d);
    bit hit;
    int w;
    en = e; arm = a; din = d;
    if (rst) begin
      m_state = 0; m_wr = 0; m_cnt = 0; m_prev = 0; m_pv = 0; m_trig = 0; m_pre = 0;
    end else begin
      case (m_state)
        0, 3: if (a) begin m_state = 1; m_wr = 0; m_pv = 0; m_pre = 0; end
        1: if (e) begin
          hit = (m_pv != 0) && (m_prev < int'(lvl)) && (int'(d) >= int'(lvl))
                && (!PT || m_pre >= PRE);
          w = m_wr;
          if (PT || hit) begin push_wr(w, int'(d)); m_wr = (w + 1) % 256; end
          if (hit) begin m_trig = w; m_cnt = 1; m_state = (POST == 1) ? 3 : 2; end
          m_prev = int'(d); m_pv = 1;
          if (m_pre < PRE) m_pre++;
        end
        2: if (e) begin
          push_wr(m_wr, int'(d));
          m_wr = (m_wr + 1) % 256;
          m_cnt++;
          if (m_cnt == POST) m_state = 3;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk); #1;
    check("state", 32'(state), m_state);
    check("done", 32'(done), (m_state == 3) ? 1 : 0);
    check("trig_addr", 32'(trig_addr), m_trig);
  endtask

  task automatic drain(input string tag);
    wr_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_addr = e.a;
      step(1'b0, 1'b0, 8'h00);
      check(tag, 32'(rd_data), 32'(e.d));
    end
  endtask

  // Ramp din=0,16,32,... with en once every 'stride' cycles until done.
  task automatic run_ramp(input int stride, input bit lat_chk, output int cyc);
    cyc = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      for (int g = 1; g < stride; g++) begin
        step(1'b0, 1'b0, 8'($urandom));
        cyc++;
      end
      step(1'b1, 1'b0, 8'(i * 16));
      cyc++;
      if (lat_chk && i == 9) check("trig_latency", 32'(rd_data), 128);
    end
  endtask

  task automatic read_at(input string tag, input int a, input int exp);
    rd_addr = a[7:0];
    step(1'b0, 1'b0, 8'h00);
    check(tag, 32'(rd_data), exp);
  endtask

  int c1, c3;

  initial begin
    lvl = 8'd128; rd_addr = '0; en = 0; arm = 0; din = 0;
    sbq.delete();
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_state", 32'(state), 0);
    rst = 1'b0;

`ifndef PRETRIG_EN
    // Ramp: trigger on 112->128, trigger sample at address 0
    rd_addr = '0;
    step(1'b1, 1'b1, 8'hAA);
    run_ramp(1, 1'b1, c1);
    check("ramp_done", 32'(done), 1);
    check("ramp_cycles", c1, 24);
    check("ramp_trig_addr", 32'(trig_addr), 0);
    check("ramp_sb_size", sbq.size(), 16);
    drain("ramp_rd");
    read_at("ramp_mem0", 0, 128);
    read_at("ramp_mem7", 7, 240);
    read_at("ramp_mem8", 8, 0);

    // No rising edge while held high; arm from DONE, arm ignored while ARMED
    step(1'b0, 1'b1, 8'h00);
    check("rearm_done_drop", 32'(done), 0);
    for (int i = 0; i < 100; i++) step(1'b1, (i == 50), 8'd200);
    check("hold_state", 32'(state), 1);
    step(1'b1, 1'b0, 8'd100);
    check("no_trig_100", 32'(state), 1);
    step(1'b1, 1'b0, 8'd130);
    check("trig_130", 32'(state), 2);
    for (int i = 0; i < 15 && !done; i++) step(1'b1, (i == 3), 8'(131 + i));
    check("hold_done", 32'(done), 1);
    drain("hold_rd");

    // Sparse strobe: same contents, three times the cycles
    step(1'b0, 1'b1, 8'h00);
    run_ramp(3, 1'b0, c3);
    check("sparse_done", 32'(done), 1);
    check("sparse_cycles", c3, 3 * c1);
    drain("sparse_rd");

    // Reset after 5 capture writes, partial window kept
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 8'(i * 16));
    check("mid_state", 32'(state), 2);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'hEE);
    rst = 1'b0;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_sb_size", sbq.size(), 5);
    drain("mid_rd");
    step(1'b0, 1'b1, 8'h00);
    run_ramp(1, 1'b0, c1);
    check("mid_rearm_done", 32'(done), 1);
    drain("mid_rearm_rd");
`else
    // Pre-trigger: 8 ARMED writes, trigger at address 8, window starts at 4
    step(1'b1, 1'b1, 8'hAA);
    run_ramp(1, 1'b0, c1);
    check("pt_done", 32'(done), 1);
    check("pt_trig_addr", 32'(trig_addr), 8);
    check("pt_cycles", c1, 20);
    check("pt_sb_size", sbq.size(), 20);
    drain("pt_rd");
    read_at("pt_win_start", 4, 64);
    read_at("pt_last", 19, 48);
    read_at("pt_trig", 8, 128);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
